video_mode_ctrl: RTL and testbench

Frame-synchronous mode controller for the camera image path. It sits between the OV5640 capture stream and the display/DDR writer. It selects one of three output formats per frame:

- RGB565 passthrough
- grayscale
- binarized

It aligns the raw RGB stream with the 3-cycle grayscale converter output and switches mode only at frame boundaries. It also checks line and frame geometry and counts frames.

---
 rtl/video_mode_ctrl_if.sv | 33 +++
 rtl/video_mode_ctrl.sv | 169 ++++++++++++++++
 tb/tb_video_mode_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_mode_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | video_mode_ctrl_if : capture-in / formatted-out bundle            |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
interface video_mode_ctrl_if;
    logic [1:0]  mode_req;
    logic        mode_req_vld;
    logic        rgb_de;
    logic        rgb_hsync;
    logic        rgb_vsync;
    logic [15:0] rgb_data;
    logic [7:0]  gray_data;
    logic        out_de;
    logic        out_hsync;
    logic        out_vsync;
    logic [15:0] out_data;
    logic [1:0]  mode_cur;
    logic [15:0] frame_cnt;
    logic        line_err;
    logic        frame_err;

    modport master (
        output mode_req, mode_req_vld, rgb_de, rgb_hsync, rgb_vsync, rgb_data, gray_data,
        input  out_de, out_hsync, out_vsync, out_data, mode_cur, frame_cnt, line_err, frame_err
    );

    modport slave (
        input  mode_req, mode_req_vld, rgb_de, rgb_hsync, rgb_vsync, rgb_data, gray_data,
        output out_de, out_hsync, out_vsync, out_data, mode_cur, frame_cnt, line_err, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/video_mode_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | video_mode_ctrl : frame-synchronous RGB565/gray/binary selector   |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module video_mode_ctrl #(
    parameter int         H_ACTIVE = 1024,
    parameter int         V_ACTIVE = 768,
    parameter int         LAT      = 3,
    parameter logic [7:0] BIN_TH   = 8'd128
) (
    input  logic             clk,
    input  logic             rst_n,
    video_mode_ctrl_if.slave bus
);
    localparam logic [10:0] H_CHK    = 11'(H_ACTIVE);
    localparam logic [11:0] V_CHK    = 12'(V_ACTIVE);
    localparam logic [10:0] PIX_MAX  = 11'h7FF;
    localparam logic [11:0] LINE_MAX = 12'hFFF;

    typedef enum logic [0:0] {WAIT_VS = 1'b0, RUN = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [LAT-1:0]       de_sr_q, de_sr_d, hs_sr_q, hs_sr_d, vs_sr_q, vs_sr_d;
    logic [LAT-1:0][15:0] d_sr_q, d_sr_d;
    logic                 vs_prev_q, vs_prev_d, de_prev_q, de_prev_d;
    logic [1:0]           pending_q, pending_d, mode_cur_q, mode_cur_d;
    logic [10:0]          pix_cnt_q, pix_cnt_d;
    logic [11:0]          line_cnt_q, line_cnt_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 line_bad_q, line_bad_d, line_err_q, line_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 out_de_q, out_de_d, out_hs_q, out_hs_d, out_vs_q, out_vs_d;
    logic [15:0]          out_data_q, out_data_d;

    logic        de_a, hs_a, vs_a, vs_rise, de_fall, req_ok, run_eff;
    logic [15:0] d_a;
    logic [1:0]  mode_new, mode_eff;

    assign de_a     = de_sr_q[LAT-1];
    assign hs_a     = hs_sr_q[LAT-1];
    assign vs_a     = vs_sr_q[LAT-1];
    assign d_a      = d_sr_q[LAT-1];
    assign vs_rise  = vs_a & ~vs_prev_q;
    assign de_fall  = ~de_a & de_prev_q;
    assign req_ok   = bus.mode_req_vld & (bus.mode_req != 2'd3);
    // A request landing on the boundary cycle bypasses pending and owns the new frame.
    assign mode_new = req_ok ? bus.mode_req : pending_q;
    assign mode_eff = vs_rise ? mode_new : mode_cur_q;
    assign run_eff  = (state_q == RUN) | vs_rise;

    assign bus.out_de    = out_de_q;
    assign bus.out_hsync = out_hs_q;
    assign bus.out_vsync = out_vs_q;
    assign bus.out_data  = out_data_q;
    assign bus.mode_cur  = mode_cur_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.line_err  = line_err_q;
    assign bus.frame_err = frame_err_q;

    always_comb begin
        state_d     = state_q;
        de_sr_d     = de_sr_q;
        hs_sr_d     = hs_sr_q;
        vs_sr_d     = vs_sr_q;
        d_sr_d      = d_sr_q;
        pending_d   = pending_q;
        mode_cur_d  = mode_cur_q;
        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        frame_cnt_d = frame_cnt_q;
        line_bad_d  = 1'b0;
        line_err_d  = line_bad_q;
        frame_err_d = 1'b0;
        vs_prev_d   = vs_a;
        de_prev_d   = de_a;

        de_sr_d[0] = bus.rgb_de;
        hs_sr_d[0] = bus.rgb_hsync;
        vs_sr_d[0] = bus.rgb_vsync;
        d_sr_d[0]  = bus.rgb_data;
        for (int i = 1; i < LAT; i++) begin
            de_sr_d[i] = de_sr_q[i-1];
            hs_sr_d[i] = hs_sr_q[i-1];
            vs_sr_d[i] = vs_sr_q[i-1];
            d_sr_d[i]  = d_sr_q[i-1];
        end

        if (de_a) begin
            if (pix_cnt_q != PIX_MAX) pix_cnt_d = pix_cnt_q + 11'd1;
        end else begin
            pix_cnt_d = '0;
            if (de_fall) begin
                // Partial lines before the first frame boundary are not judged.
                line_bad_d = (state_q == RUN) && (pix_cnt_q != H_CHK);
                if (line_cnt_q != LINE_MAX) line_cnt_d = line_cnt_q + 12'd1;
            end
        end

        if (req_ok) pending_d = bus.mode_req;

        if (vs_rise) begin
            state_d    = RUN;
            mode_cur_d = mode_new;
            line_cnt_d = '0;
            if (state_q == RUN) begin
                frame_err_d = (line_cnt_q != V_CHK);
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end

        out_hs_d   = hs_a;
        out_vs_d   = vs_a;
        out_de_d   = run_eff & de_a;
        out_data_d = '0;
        if (run_eff && de_a) begin
            case (mode_eff)
                2'd1:    out_data_d = {bus.gray_data[7:3], bus.gray_data[7:2], bus.gray_data[7:3]};
                2'd2:    out_data_d = (bus.gray_data >= BIN_TH) ? 16'hFFFF : 16'h0000;
                default: out_data_d = d_a;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_VS;
            de_sr_q     <= '0;
            hs_sr_q     <= '0;
            vs_sr_q     <= '0;
            d_sr_q      <= '0;
            vs_prev_q   <= 1'b0;
            de_prev_q   <= 1'b0;
            pending_q   <= 2'd0;
            mode_cur_q  <= 2'd0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            frame_cnt_q <= '0;
            line_bad_q  <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            out_de_q    <= 1'b0;
            out_hs_q    <= 1'b0;
            out_vs_q    <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            de_sr_q     <= de_sr_d;
            hs_sr_q     <= hs_sr_d;
            vs_sr_q     <= vs_sr_d;
            d_sr_q      <= d_sr_d;
            vs_prev_q   <= vs_prev_d;
            de_prev_q   <= de_prev_d;
            pending_q   <= pending_d;
            mode_cur_q  <= mode_cur_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            line_bad_q  <= line_bad_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            out_de_q    <= out_de_d;
            out_hs_q    <= out_hs_d;
            out_vs_q    <= out_vs_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_video_mode_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_video_mode_ctrl : reference-model bench for video_mode_ctrl    |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_video_mode_ctrl;
    localparam int H   = 8;
    localparam int V   = 4;
    localparam int LAT = 3;
    localparam int HD  = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    video_mode_ctrl_if bus();

    video_mode_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .LAT(LAT), .BIN_TH(8'd128)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] pix;
        logic [7:0]  y;
        logic [15:0] exp_data;
        logic [1:0]  exp_mode;
    } vec_t;
    vec_t tbl[8];

    int total = 0;
    int bad = 0;

    // input history, indexed by cycle since the last reset release
    bit          vs_h[HD];
    bit          de_h[HD];
    bit          hs_h[HD];
    logic [15:0] d_h[HD];
    logic [7:0]  y_h[HD];
    int          cyc = 0;
    int          rb = 0;
    logic [7:0]  y_cur = 8'h00;

    // reference model state
    bit running;
    int pend, mode, fcnt, lines;
    bit le_prev;

    int fc, req_at;
    logic [1:0]  req_v;
    bit          seen_de;
    logic [15:0] first_data;
    int lerr_seen, ferr_seen;
    int in_first = -1;
    int out_first = -1;

    function automatic bit vsv(int a); return (a < rb) ? 1'b0 : vs_h[a % HD]; endfunction
    function automatic bit dev(int a); return (a < rb) ? 1'b0 : de_h[a % HD]; endfunction
    function automatic bit hsv(int a); return (a < rb) ? 1'b0 : hs_h[a % HD]; endfunction
    function automatic logic [15:0] dv(int a); return (a < rb) ? 16'h0 : d_h[a % HD]; endfunction
    function automatic logic [7:0] yv(int a); return (a < rb) ? 8'h0 : y_h[a % HD]; endfunction

    function automatic logic [15:0] fmt(int m, logic [15:0] p, logic [7:0] y);
        if (m == 1) return {y[7:3], y[7:2], y[7:3]};
        if (m == 2) return (y >= 8'd128) ? 16'hFFFF : 16'h0000;
        return p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        running = 0; pend = 0; mode = 0; fcnt = 0; lines = 0; le_prev = 0;
        rb = cyc;
    endtask

    task automatic step();
        int a, len, mnew, meff, idx;
        bit vs_a, vs_p, de_a, de_p, rise, fall, run_eff, bad_now, e_ferr, e_lerr, e_de;
        logic [15:0] e_data;
        idx = cyc % HD;
        vs_h[idx] = bus.rgb_vsync; de_h[idx] = bus.rgb_de; hs_h[idx] = bus.rgb_hsync;
        d_h[idx] = bus.rgb_data; y_h[idx] = y_cur;
        if (bus.rgb_de && in_first < 0) in_first = cyc;
        a = cyc - LAT;
        bus.gray_data = yv(a);
        vs_a = vsv(a); vs_p = vsv(a - 1); de_a = dev(a); de_p = dev(a - 1);
        rise = vs_a && !vs_p;
        fall = !de_a && de_p;
        mnew = (bus.mode_req_vld && bus.mode_req != 2'd3) ? int'(bus.mode_req) : pend;
        if (bus.mode_req_vld && bus.mode_req != 2'd3) pend = int'(bus.mode_req);
        run_eff = running || rise;
        meff = rise ? mnew : mode;
        bad_now = 0;
        if (fall) begin
            len = 0;
            for (int j = a - 1; j >= rb && dev(j) && len < 2047; j--) len++;
            if (running && len != H) bad_now = 1;
            lines++;
        end
        e_ferr = 0;
        if (rise) begin
            if (running) begin
                e_ferr = (lines != V);
                fcnt = (fcnt + 1) % 65536;
            end
            lines = 0; mode = mnew; running = 1;
        end
        e_de = run_eff && de_a;
        e_data = e_de ? fmt(meff, dv(a), yv(a)) : 16'h0;
        e_lerr = le_prev;
        le_prev = bad_now;
        cyc++;
        @(posedge clk); #1;
        chk("out_de", bus.out_de, e_de);
        chk("out_hsync", bus.out_hsync, hsv(a));
        chk("out_vsync", bus.out_vsync, vs_a);
        chk("out_data", bus.out_data, e_data);
        chk("mode_cur", bus.mode_cur, meff[1:0]);
        chk("frame_cnt", bus.frame_cnt, fcnt[15:0]);
        chk("line_err", bus.line_err, e_lerr);
        chk("frame_err", bus.frame_err, e_ferr);
        if (bus.out_de && out_first < 0) out_first = cyc;
        if (bus.out_de && !seen_de) begin seen_de = 1; first_data = bus.out_data; end
        if (bus.line_err) lerr_seen++;
        if (bus.frame_err) ferr_seen++;
    endtask

    task automatic cyc1(input bit de, input bit hs, input bit vs, input logic [15:0] d,
                        input logic [7:0] y, input bit rnd);
        bus.rgb_de = de; bus.rgb_hsync = hs; bus.rgb_vsync = vs; bus.rgb_data = d; y_cur = y;
        if (fc == req_at) begin
            bus.mode_req_vld = 1'b1; bus.mode_req = req_v;
        end else if (rnd && $urandom_range(0, 15) == 0) begin
            bus.mode_req_vld = 1'b1; bus.mode_req = 2'($urandom_range(0, 3));
        end else begin
            bus.mode_req_vld = 1'b0;
        end
        fc++;
        step();
    endtask

    task automatic strobe_req(input logic [1:0] m);
        fc = 0; req_at = 0; req_v = m;
        cyc1(0, 0, 0, 16'h0, 8'h0, 0);
        req_at = -1;
    endtask

    task automatic run_frame(input logic [15:0] pix, input logic [7:0] y, input bit rnd,
                             input int rq_cyc, input logic [1:0] rq_val,
                             input int short_line, input int nlines);
        fc = 0; req_at = rq_cyc; req_v = rq_val;
        seen_de = 0; lerr_seen = 0; ferr_seen = 0;
        for (int i = 0; i < 2; i++) cyc1(0, 0, 1, 16'h0, 8'h0, rnd);
        for (int i = 0; i < 3; i++) cyc1(0, 0, 0, 16'h0, 8'h0, rnd);
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < ((l == short_line) ? H - 1 : H); p++)
                cyc1(1, 0, 0, rnd ? 16'($urandom) : pix, rnd ? 8'($urandom) : y, rnd);
            for (int i = 0; i < 4; i++) cyc1(0, (i < 2), 0, 16'h0, 8'h0, rnd);
        end
        for (int i = 0; i < 2; i++) cyc1(0, 0, 0, 16'h0, 8'h0, rnd);
        req_at = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fsave;
        tbl[0] = '{2'd0, 16'hF800, 8'h00, 16'hF800, 2'd0};
        tbl[1] = '{2'd1, 16'h0000, 8'h80, 16'h8410, 2'd1};
        tbl[2] = '{2'd1, 16'hABCD, 8'h5A, 16'h5ACB, 2'd1};
        tbl[3] = '{2'd2, 16'h1234, 8'h7F, 16'h0000, 2'd2};
        tbl[4] = '{2'd2, 16'h1234, 8'h80, 16'hFFFF, 2'd2};
        tbl[5] = '{2'd3, 16'h1234, 8'h80, 16'hFFFF, 2'd2};
        tbl[6] = '{2'd1, 16'h0000, 8'hFF, 16'hFFFF, 2'd1};
        tbl[7] = '{2'd0, 16'h07E0, 8'h33, 16'h07E0, 2'd0};

        bus.mode_req = 2'd0; bus.mode_req_vld = 1'b0; bus.rgb_de = 1'b0;
        bus.rgb_hsync = 1'b0; bus.rgb_vsync = 1'b0; bus.rgb_data = 16'h0; bus.gray_data = 8'h0;
        req_at = -1; fc = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_de", bus.out_de, 0);
        chk("rst_out_sync", {bus.out_hsync, bus.out_vsync}, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_mode_cur", bus.mode_cur, 0);
        chk("rst_frame_cnt", bus.frame_cnt, 0);
        chk("rst_errs", {bus.line_err, bus.frame_err}, 0);
        #2 rst_n = 1'b1;
        model_reset();

        // two passthrough frames
        run_frame(16'hF800, 8'h00, 0, -1, 2'd0, -1, V);
        chk("first_frame_cnt", bus.frame_cnt, 0);
        chk("first_data", first_data, 16'hF800);
        chk("latency", out_first - in_first, 4);
        run_frame(16'hF800, 8'h00, 0, -1, 2'd0, -1, V);
        chk("second_frame_cnt", bus.frame_cnt, 1);
        chk("no_errs", lerr_seen + ferr_seen, 0);

        // mid-frame request waits for the next boundary
        run_frame(16'hFFFF, 8'hFF, 0, 20, 2'd1, -1, V);
        chk("midreq_mode_hold", bus.mode_cur, 0);
        run_frame(16'h1234, 8'hFF, 0, -1, 2'd0, -1, V);
        chk("midreq_mode_new", bus.mode_cur, 1);
        chk("midreq_data", first_data, 16'hFFFF);

        // request on the aligned boundary cycle, then a reserved request
        strobe_req(2'd0);
        run_frame(16'h5555, 8'h90, 0, 3, 2'd2, -1, V);
        chk("bypass_mode", bus.mode_cur, 2);
        chk("bypass_data", first_data, 16'hFFFF);
        run_frame(16'h5555, 8'h10, 0, 20, 2'd3, -1, V);
        run_frame(16'h5555, 8'h10, 0, -1, 2'd0, -1, V);
        chk("reserved_mode", bus.mode_cur, 2);
        chk("reserved_data", first_data, 16'h0000);

        // geometry errors: one short line, one short frame
        fsave = int'(bus.frame_cnt);
        run_frame(16'h0F0F, 8'h20, 0, -1, 2'd0, 1, V - 1);
        chk("line_err_count", lerr_seen, 1);
        run_frame(16'h0F0F, 8'h20, 0, -1, 2'd0, -1, V);
        chk("frame_err_count", ferr_seen, 1);
        chk("frame_cnt_after_err", bus.frame_cnt, 16'(fsave + 2));

        // format table
        for (int i = 0; i < 8; i++) begin
            strobe_req(tbl[i].mode);
            run_frame(tbl[i].pix, tbl[i].y, 0, -1, 2'd0, -1, V);
            chk("tbl_data", first_data, tbl[i].exp_data);
            chk("tbl_mode", bus.mode_cur, tbl[i].exp_mode);
        end

        // randomized frames with random requests and geometry
        for (int i = 0; i < 6; i++)
            run_frame(16'h0, 8'h0, 1, -1, 2'd0, int'($urandom_range(0, 6)) - 2,
                      int'($urandom_range(V - 1, V)));

        // reset mid-frame while in gray mode
        strobe_req(2'd1);
        run_frame(16'hAAAA, 8'hC0, 0, -1, 2'd0, -1, V);
        chk("pre_rst_mode", bus.mode_cur, 1);
        fc = 0;
        for (int i = 0; i < 2; i++) cyc1(0, 0, 1, 16'h0, 8'h0, 0);
        for (int i = 0; i < 3; i++) cyc1(0, 0, 0, 16'h0, 8'h0, 0);
        for (int i = 0; i < 5; i++) cyc1(1, 0, 0, 16'hAAAA, 8'hC0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_de", bus.out_de, 0);
        chk("rst_mid_out_data", bus.out_data, 0);
        chk("rst_mid_mode", bus.mode_cur, 0);
        chk("rst_mid_fcnt", bus.frame_cnt, 0);
        bus.rgb_de = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        seen_de = 0;
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < H; p++) cyc1(1, 0, 0, 16'hAAAA, 8'hC0, 0);
            for (int i = 0; i < 4; i++) cyc1(0, (i < 2), 0, 16'h0, 8'h0, 0);
        end
        chk("post_rst_blank", seen_de, 0);
        run_frame(16'h3C3C, 8'hC0, 0, -1, 2'd0, -1, V);
        chk("post_rst_mode", bus.mode_cur, 0);
        chk("post_rst_data", first_data, 16'h3C3C);
        chk("post_rst_fcnt", bus.frame_cnt, 0);
        for (int i = 0; i < 6; i++) cyc1(0, 0, 0, 16'h0, 8'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
